// File: rtl/gray_bin_pkg.sv
// rtl/gray_bin_pkg.sv - shared types, step codes and Gray decode helper for gray_bin
package gray_bin_pkg;

    localparam logic [1:0] STEP_HOLD = 2'd0;
    localparam logic [1:0] STEP_UP   = 2'd1;
    localparam logic [1:0] STEP_DN   = 2'd2;
    localparam logic [1:0] STEP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD = STEP_HOLD,
        S_UP   = STEP_UP,
        S_DN   = STEP_DN,
        S_ERR  = STEP_ERR
    } step_t;

    // Decodes the low w bits of g; the running XOR walks from the MSB down.
    function automatic logic [15:0] gray2bin(input logic [15:0] g, input int w);
        logic [15:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_bin_step.sv
// rtl/gray_bin_step.sv - combinational step classifier (hold / up / down / error)
module gray_bin_step
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    input  logic [WIDTH-1:0] prev_bin,
    input  logic             first_flag,
    output logic             dir,
    output logic             hold,
    output logic             err
);

    logic [WIDTH-1:0] d;
    step_t            step;

    always_comb begin
        d = bin - prev_bin;
        // Modular difference makes max<->0 wrap a legal single step.
        if (d == '0)
            step = S_HOLD;
        else if (d == WIDTH'(1))
            step = S_UP;
        else if (d == '1)
            step = S_DN;
        else
            step = S_ERR;

        dir  = 1'b0;
        hold = 1'b0;
        err  = 1'b0;
        if (!first_flag) begin
            case (step)
                S_HOLD: hold = 1'b1;
                S_UP:   dir  = 1'b1;
                S_DN:   ;
                S_ERR:  err  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/gray_bin.sv
// rtl/gray_bin.sv - 2-stage Gray-to-binary decoder with step check; GRAY_BIN_ONEHOT_EN adds out_onehot
module gray_bin
    import gray_bin_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_dir,
    output logic             out_hold,
    output logic             step_err
`ifdef GRAY_BIN_ONEHOT_EN
    ,
    output logic [2**WIDTH-1:0] out_onehot
`endif
);

    logic             a_valid;
    logic [WIDTH-1:0] a_gray;
    logic [WIDTH-1:0] a_bin;
    logic [WIDTH-1:0] prev_bin;
    logic             first_flag;
    logic             in_xfer;
    logic             b_load;
    logic             s_dir;
    logic             s_hold;
    logic             s_err;

    assign in_ready = !a_valid || !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign b_load   = a_valid && (!out_valid || out_ready);
    assign a_bin    = WIDTH'(gray2bin(16'(a_gray), WIDTH));

    gray_bin_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .bin       (a_bin),
        .prev_bin  (prev_bin),
        .first_flag(first_flag),
        .dir       (s_dir),
        .hold      (s_hold),
        .err       (s_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid    <= 1'b0;
            a_gray     <= '0;
            out_valid  <= 1'b0;
            out_bin    <= '0;
            out_dir    <= 1'b0;
            out_hold   <= 1'b0;
            step_err   <= 1'b0;
            prev_bin   <= '0;
            first_flag <= 1'b1;
        end else begin
            if (in_xfer) begin
                a_valid <= 1'b1;
                a_gray  <= in_gray;
            end else if (b_load) begin
                a_valid <= 1'b0;
            end

            // prev_bin follows every stage-B load, erroneous samples included.
            if (b_load) begin
                out_valid  <= 1'b1;
                out_bin    <= a_bin;
                out_dir    <= s_dir;
                out_hold   <= s_hold;
                step_err   <= s_err;
                prev_bin   <= a_bin;
                first_flag <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef GRAY_BIN_ONEHOT_EN
    logic [2**WIDTH-1:0] onehot_next;

    always_comb begin
        onehot_next        = '0;
        onehot_next[a_bin] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_onehot <= '0;
        else if (b_load)
            out_onehot <= onehot_next;
    end
`endif

endmodule

// File: tb/tb_gray_bin.sv
// tb/tb_gray_bin.sv - randomized scoreboard bench for gray_bin with directed literal checks
module tb_gray_bin;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_gray = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_bin;
    logic         out_dir;
    logic         out_hold;
    logic         step_err;
`ifdef GRAY_BIN_ONEHOT_EN
    logic [2**W-1:0] out_onehot;
`endif

    gray_bin #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_gray  (in_gray),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bin  (out_bin),
        .out_dir  (out_dir),
        .out_hold (out_hold),
        .step_err (step_err)
`ifdef GRAY_BIN_ONEHOT_EN
        ,
        .out_onehot(out_onehot)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int dir;
        int hold;
        int err;
        int t;
    } ent_t;

    ent_t q[$];
    ent_t log_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   m_prev = 0;
    bit   m_first = 1'b1;
    bit   chk_en = 1'b0;
    bit   rnd_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b & MASK;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    // Reference model: sample order is preserved, so classification at acceptance time matches stage B.
    always @(posedge clk) begin
        if (chk_en) begin
            cyc++;
            if (rst) begin
                q.delete();
                m_first = 1'b1;
            end else begin
                if (out_valid && out_ready) begin
                    log_q.push_back('{out_bin, out_dir, out_hold, step_err, 0});
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    ent_t e;
                    int   d;
                    e.bin = g2b(int'(in_gray));
                    d = (e.bin - m_prev) & MASK;
                    e.dir = 0; e.hold = 0; e.err = 0;
                    if (!m_first) begin
                        if (d == 0) e.hold = 1;
                        else if (d == 1) e.dir = 1;
                        else if (d != MASK) e.err = 1;
                    end
                    e.t = cyc;
                    m_prev = e.bin;
                    m_first = 1'b0;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("out_valid", 32'(out_valid), 32'((q.size() > 0) && (q[0].t < cyc)));
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            if (out_valid && q.size() > 0) begin
                chk("out_bin", 32'(out_bin), 32'(q[0].bin));
                chk("out_dir", 32'(out_dir), 32'(q[0].dir));
                chk("out_hold", 32'(out_hold), 32'(q[0].hold));
                chk("step_err", 32'(step_err), 32'(q[0].err));
`ifdef GRAY_BIN_ONEHOT_EN
                chk("out_onehot", 32'(out_onehot), 32'(1) << q[0].bin);
`endif
            end
        end
    end

    task automatic send(input int g);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_gray  = W'(g);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) break;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept of gray %0h", g);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_rst();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int idx, input int b, input int d, input int h, input int e);
        if (idx >= log_q.size()) begin
            tests++;
            fails++;
            $display("FAIL %s: got %0d outputs expected more than %0d", nm, log_q.size(), idx);
        end else begin
            chk({nm, "_bin"}, 32'(log_q[idx].bin), 32'(b));
            chk({nm, "_dir"}, 32'(log_q[idx].dir), 32'(d));
            chk({nm, "_hold"}, 32'(log_q[idx].hold), 32'(h));
            chk({nm, "_err"}, 32'(log_q[idx].err), 32'(e));
        end
    endtask

    initial begin
        int v;
        int r;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bin", 32'(out_bin), 32'd0);
        chk("rst_flags", {29'd0, out_dir, out_hold, step_err}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // Counting up from reset
        log_q.delete();
        send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
        idle(4);
        chk("t1_count", 32'(log_q.size()), 32'd5);
        chk_out("t1_0", 0, 0, 0, 0, 0);
        chk_out("t1_1", 1, 1, 1, 0, 0);
        chk_out("t1_2", 2, 2, 1, 0, 0);
        chk_out("t1_3", 3, 3, 1, 0, 0);
        chk_out("t1_4", 4, 4, 1, 0, 0);

        // Wrap-around both directions
        log_q.delete();
        send(4'b1000); send(4'b0000); send(4'b0000); send(4'b1000);
        idle(4);
        chk_out("t2_up_wrap", 1, 0, 1, 0, 0);
        chk_out("t2_hold", 2, 0, 0, 1, 0);
        chk_out("t2_dn_wrap", 3, 15, 0, 0, 0);

        // Jump then recovery relative to the erroneous sample
        log_q.delete();
        send(4'b0001); send(4'b0111); send(4'b0101);
        idle(4);
        chk_out("t3_jump", 1, 5, 0, 0, 1);
        chk_out("t3_after", 2, 6, 1, 0, 0);

        // Backpressure: 6 samples against a 5-cycle stall
        log_q.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(b2g(i));
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(negedge clk);
                chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("t4_count", 32'(log_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk("t4_order", 32'(log_q[i].bin), 32'(i));

        // Reset with both stages full
        out_ready = 1'b0;
        send(4'b0011); send(4'b0010);
        pulse_rst();
        @(negedge clk);
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        log_q.delete();
        send(4'b1100); send(4'b1100);
        idle(4);
        chk("t5_count", 32'(log_q.size()), 32'd2);
        chk_out("t5_first", 0, 8, 0, 0, 0);
        chk_out("t5_hold", 1, 8, 0, 1, 0);

`ifdef GRAY_BIN_ONEHOT_EN
        out_ready = 1'b0;
        send(4'b1101);
        idle(2);
        @(negedge clk);
        chk("t6_onehot", 32'(out_onehot), 32'h0200);
        out_ready = 1'b1;
        idle(3);
`endif

        // Randomized traffic with random backpressure and occasional reset
        v = 0;
        fork
            begin
                for (int n = 0; n < 600; n++) begin
                    r = $urandom_range(0, 99);
                    if (r < 2) pulse_rst();
                    else if (r < 14) idle($urandom_range(1, 3));
                    r = $urandom_range(0, 99);
                    if (r < 40) v = (v + 1) & MASK;
                    else if (r < 70) v = (v - 1) & MASK;
                    else if (r < 80) v = v;
                    else v = $urandom_range(0, MASK);
                    send(b2g(v));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        idle(5);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_bin.md
Name: gray_bin

Overview:
Streaming Gray-to-binary decoder with step checking; the inverse of the binary-to-Gray encode path.
- Accepts WIDTH-bit Gray codes on a valid/ready input, emits the binary value, count direction and a step-error flag on a valid/ready output.
- Used behind Gray-coded position sources and pointer samplers, where consecutive codes must differ by exactly one count.
- 2-stage registered pipeline, full throughput, stall-safe under backpressure.

Parameters:
WIDTH, 4, code width in bits (2..16)

Ports:
clk  input  1  rising-edge clock, only clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_gray is valid
in_ready  output  1  block accepts in_gray this cycle
in_gray  input  WIDTH  Gray-coded sample
out_valid  output  1  output fields are valid
out_ready  input  1  consumer accepts output this cycle
out_bin  output  WIDTH  decoded binary value
out_dir  output  1  1 = count up, 0 = count down/hold (vs. previous accepted sample)
out_hold  output  1  value equals previous sample
step_err  output  1  value is not prev, prev+1 or prev-1 (mod 2^WIDTH)

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: out_valid=0, out_bin=0, out_dir=0, out_hold=0, step_err=0.
  - Both pipeline stages are emptied and first_flag is set.
  - Reset mid-stream discards all in-flight samples; nothing is emitted for them.
- Transfer rules:
  - A transfer occurs when valid & ready on an interface at a clk edge.
  - in_ready depends only on internal state and out_ready, never on in_valid.
- Stage A register: a_valid, a_gray.
  - Loads in_gray on an input transfer.
  - Stage A may accept when empty or when stage A moves to stage B in the same cycle.
- Stage B (output register): out_valid, out_bin, out_dir, out_hold, step_err.
  - Loads when a_valid and (!out_valid or out_ready).
  - Binary conversion: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i] for i = WIDTH-2 down to 0.
- in_ready = !a_valid | !out_valid | out_ready.
- Latency: input transfer at edge N → out_valid at edge N+1 when unstalled (2 register stages incl. input capture). Throughput: 1 sample/cycle.
- Step check against prev_bin, the last value loaded into stage B:
  - d = (bin - prev_bin) mod 2^WIDTH.
  - d = 0: hold=1, dir=0, err=0.
  - d = 1: dir=1, err=0.
  - d = 2^WIDTH-1: dir=0, err=0.
  - Any other d: err=1, dir=0, hold=0.
  - Wrap-around (max→0 or 0→max) is a legal single step.
- First sample after reset: no comparison; err=0, hold=0, dir=0; first_flag clears and prev_bin loads.
- prev_bin updates on every stage-B load, including erroneous samples.
- Backpressure: while out_valid & !out_ready, stage B holds all fields stable; stage A fills and then deasserts in_ready. No sample is lost or duplicated.
- Simultaneous output and input transfer in one cycle is legal and keeps full rate.

Optional Feature:
Macro GRAY_BIN_ONEHOT_EN.
- Defined: adds output port out_onehot [2**WIDTH-1:0], registered in stage B alongside out_bin, with bit out_bin set and all others 0. It is 0 after reset and stable during stall.
- Undefined: the port does not exist and no decode logic is built.

Decomposition:
- Package gray_bin_pkg:
  - Function gray2bin(g) (parameterised via WIDTH argument pattern).
  - Localparam constants for step-check codes (STEP_HOLD, STEP_UP, STEP_DN, STEP_ERR).
  - Typedef step_t (2-bit enum).
- Sub-module gray_bin_step: combinational step classifier (bin, prev_bin, first_flag → dir, hold, err). The conversion itself stays inline.

Test Plan:
1. WIDTH=4, out_ready=1, feed Gray 0000,0001,0011,0010,0110 → out_bin 0,1,2,3,4, out_dir 0,1,1,1,1, step_err all 0, each output 1 cycle after acceptance.
2. Wrap: feed Gray 1000 (bin 15) then 0000 → out_bin 15 then 0, second sample dir=1, err=0. Reverse (0000 then 1000) → dir=0, err=0.
3. Jump: feed 0001 (1) then 0111 (5) → second output step_err=1. Then 0101 (6) → err=0, dir=1, since prev_bin=5.
4. Backpressure: continuous in_valid with 0000..0101, out_ready=0 for 5 cycles → in_ready falls after 2 accepted samples, outputs held stable. On release, all 6 values emerge in order with no gaps or duplicates.
5. Reset mid-stream: rst=1 for 1 cycle with both stages full → out_valid=0 next cycle. Next sample 1100 (bin 8) → err=0, hold=0 (first sample).
6. With GRAY_BIN_ONEHOT_EN: Gray 1101 (bin 9) → out_onehot = 16'h0200. Repeat same code → out_hold=1.
